// File: rtl/uart_rx_fifo_if_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default
// oversample ratio, register-file addresses and the majority-vote helper.
package uart_rx_fifo_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  // Wishbone register map of the UART peripheral
  localparam logic [7:0] ADDR_TX       = 8'h00;
  localparam logic [7:0] ADDR_RX       = 8'h01;
  localparam logic [7:0] ADDR_FREQ_DIV = 8'h02;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // 2-of-3 majority used for the mid-bit vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if_baud_tick.sv
// Oversample tick prescaler. The divider is captured on clear_i so a frame
// keeps a constant rate even if software rewrites the divider mid-frame.
// clear_i also zeroes the count so ticks are phase-aligned to the start edge.
module uart_rx_fifo_if_baud_tick (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic [7:0] div_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;

  // Next count: restart on clear, wrap at the latched divider
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    div_d = div_q;
    if (clear_i) begin
      cnt_d = 8'd0;
      div_d = div_i;
    end else if (cnt_q == div_q) begin
      cnt_d = 8'd0;
    end
  end

  // Prescaler and divider latch registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
      div_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign tick_o = (cnt_q == div_q) && !clear_i;

endmodule

// File: rtl/uart_rx_fifo_if.sv
// 8N1 UART receiver feeding the RX FIFO. rx_bit is synchronised, sampled
// OVERSAMPLE times per bit, voted 2-of-3 around mid-bit, and a good byte is
// pushed with a one-cycle strobe. Framing, break and overrun are reported.
// The FSM leaves STOP at mid stop bit so back-to-back frames are accepted.
module uart_rx_fifo_if
  import uart_rx_fifo_if_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic [7:0]           freq_divider,
  input  logic                 fifo_full,
  input  logic                 clr_err,
  output logic                 fifo_push,
  output logic [DATA_BITS-1:0] fifo_data,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy,
  output uart_state_e          dbg_state
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev_q;
  logic                   tick;
  logic                   start_edge;
  logic                   vote;
  logic                   stop_vote;

  uart_state_e            state_q, state_d;
  logic [SW-1:0]          s_q;
  logic [IW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   samp0_q, samp1_q;

  logic                   push_q, push_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   ovr_q, ovr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;

  // Synchroniser chain plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '1;
      rxs_prev_q <= HIGH;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_bit};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign start_edge = (state_q == ST_IDLE) && rxs_prev_q && !rxs;
  // Third sample is taken live on the vote-completion tick
  assign vote       = maj3(samp0_q, samp1_q, rxs);
  assign stop_vote  = (state_q == ST_STOP) && tick && (s_q == S_V2);

  uart_rx_fifo_if_baud_tick u_baud_tick (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (start_edge),
    .div_i   (freq_divider),
    .tick_o  (tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_START;
      ST_START: begin
        if (tick && (s_q == S_V2) && vote) state_d = ST_IDLE;
        else if (tick && (s_q == S_LAST))  state_d = ST_DATA;
      end
      ST_DATA:  if (tick && (s_q == S_LAST) && (idx_q == I_LAST)) state_d = ST_STOP;
      ST_STOP:  if (tick && (s_q == S_V2)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sample counter, bit index, vote samples and data shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q     <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      samp0_q <= LOW;
      samp1_q <= LOW;
    end else if (start_edge) begin
      s_q   <= '0;
      idx_q <= '0;
    end else if (tick && (state_q != ST_IDLE)) begin
      s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
      if (s_q == S_V0) samp0_q <= rxs;
      if (s_q == S_V1) samp1_q <= rxs;
      if ((state_q == ST_DATA) && (s_q == S_V2))
        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
      if ((state_q == ST_DATA) && (s_q == S_LAST) && (idx_q != I_LAST))
        idx_q <= idx_q + 1'b1;
    end
  end

  // FSM outputs: stop-bit actions and busy flag
  always_comb begin
    push_d = stop_vote && vote && !fifo_full;
    ferr_d = stop_vote && !vote;
    brk_d  = ferr_d && (shift_q == '0);
    ovr_d  = (ovr_q && !clr_err) || (stop_vote && vote && fifo_full);
    data_d = push_d ? shift_q : data_q;
    busy   = (state_q != ST_IDLE);
  end

  // Registered strobes, sticky overrun and held byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
      ovr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      push_q <= push_d;
      ferr_q <= ferr_d;
      brk_q  <= brk_d;
      ovr_q  <= ovr_d;
      data_q <= data_d;
    end
  end

  assign fifo_push = push_q;
  assign fifo_data = data_q;
  assign frame_err = ferr_q;
  assign break_det = brk_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
// Directed bench for the UART receiver at freq_divider=3 (64 clk per bit).
module tb_uart_rx_fifo_if;
  import uart_rx_fifo_if_pkg::*;

  localparam int DIV     = 3;
  localparam int BIT_CLK = 16 * (DIV + 1);
  // 2 sync flops + 1 detect cycle, then 16 start + 128 data + 10 stop ticks
  localparam int PUSH_LAT = 2 + 1 + (DIV + 1) * (16 + 16 * 8 + 10);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_bit = 1'b1;
  logic [7:0]  freq_divider = 8'(DIV);
  logic        fifo_full = 1'b0;
  logic        clr_err = 1'b0;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic        frame_err;
  logic        break_det;
  logic        overrun;
  logic        busy;
  uart_state_e dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          push_cyc = 0;
  int          last_start_cyc = 0;
  int          ferr_cnt = 0;
  int          brk_cnt = 0;
  logic [7:0]  got_q[$];

  uart_rx_fifo_if dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .fifo_full    (fifo_full),
    .clr_err      (clr_err),
    .fifo_push    (fifo_push),
    .fifo_data    (fifo_data),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .overrun      (overrun),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (reset) begin
      if (fifo_push) begin
        got_q.push_back(fifo_data);
        push_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (break_det) brk_cnt++;
    end
  end

  // Driver tasks: all start and end on a falling clock edge
  task automatic idle(input int n);
    rx_bit = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    if (glitch) begin
      rx_bit = v;  repeat (30) @(negedge clk);
      rx_bit = ~v; repeat (4) @(negedge clk);
      rx_bit = v;  repeat (BIT_CLK - 34) @(negedge clk);
    end else begin
      rx_bit = v;
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
    last_start_cyc = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == glitch_bit));
    send_bit(stop, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fifo_push, frame_err, break_det, overrun, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {fifo_push, frame_err, break_det, overrun, busy});
    end
    n_checks++;
    if (fifo_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00", fifo_data);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b1;
    idle(20);
  endtask

  task automatic test_single;
    int n0, f0;
    n0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, -1);
    idle(40);
    n_checks++;
    if (got_q.size() - n0 !== 1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", got_q.size() - n0);
    end else begin
      n_checks++;
      if (got_q[n0] !== 8'h41) begin
        n_fail++; $display("FAIL single_data: got %h expected 41", got_q[n0]);
      end
      n_checks++;
      if (push_cyc - last_start_cyc !== PUSH_LAT) begin
        n_fail++;
        $display("FAIL single_latency: got %0d expected %0d", push_cyc - last_start_cyc, PUSH_LAT);
      end
    end
    n_checks++;
    if (ferr_cnt !== f0) begin
      n_fail++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0);
    end
  endtask

  task automatic test_back_to_back;
    int n0, f0;
    n0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hAA, 1'b1, -1);
    idle(40);
    n_checks++;
    if (got_q.size() - n0 !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_q.size() - n0);
    end else begin
      n_checks++;
      if ({got_q[n0], got_q[n0+1]} !== 16'h55AA) begin
        n_fail++; $display("FAIL b2b_data: got %h %h expected 55 aa", got_q[n0], got_q[n0+1]);
      end
    end
    n_checks++;
    if (ferr_cnt !== f0) begin
      n_fail++; $display("FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, f0);
    end
  endtask

  task automatic test_framing;
    int n0, f0, b0;
    n0 = got_q.size(); f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'h00, 1'b0, -1);
    idle(2 * BIT_CLK);
    n_checks++;
    if ({ferr_cnt - f0, brk_cnt - b0, got_q.size() - n0} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL break_frame: got ferr=%0d brk=%0d push=%0d expected 1 1 0",
               ferr_cnt - f0, brk_cnt - b0, got_q.size() - n0);
    end
    n0 = got_q.size(); f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'h80, 1'b0, -1);
    idle(2 * BIT_CLK);
    n_checks++;
    if ({ferr_cnt - f0, brk_cnt - b0, got_q.size() - n0} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL frame_err_80: got ferr=%0d brk=%0d push=%0d expected 1 0 0",
               ferr_cnt - f0, brk_cnt - b0, got_q.size() - n0);
    end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = got_q.size(); f0 = ferr_cnt;
    rx_bit = 1'b0;
    repeat (DIV + 1) @(negedge clk);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_busy_hi: got %b expected 1", busy);
    end
    idle(200);
    n_checks++;
    if ({busy, got_q.size() - n0, ferr_cnt - f0} !== {1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL glitch_idle: got busy=%b push=%0d ferr=%0d expected 0 0 0",
               busy, got_q.size() - n0, ferr_cnt - f0);
    end
    n0 = got_q.size();
    send_frame(8'hF0, 1'b1, 3);
    idle(40);
    n_checks++;
    if (got_q.size() - n0 !== 1) begin
      n_fail++; $display("FAIL glitch_bit3_count: got %0d expected 1", got_q.size() - n0);
    end else begin
      n_checks++;
      if (got_q[n0] !== 8'hF0) begin
        n_fail++; $display("FAIL glitch_bit3_data: got %h expected f0", got_q[n0]);
      end
    end
  endtask

  task automatic test_overrun;
    int n0;
    n0 = got_q.size();
    fifo_full = 1'b1;
    send_frame(8'h33, 1'b1, -1);
    idle(40);
    n_checks++;
    if ({overrun, got_q.size() - n0} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL overrun_set: got ovr=%b push=%0d expected 1 0", overrun, got_q.size() - n0);
    end
    n_checks++;
    if (fifo_data !== 8'hF0) begin
      n_fail++; $display("FAIL overrun_data_hold: got %h expected f0", fifo_data);
    end
    idle(100);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
    fifo_full = 1'b0;
    n0 = got_q.size();
    send_frame(8'h34, 1'b1, -1);
    idle(40);
    n_checks++;
    if (got_q.size() - n0 !== 1) begin
      n_fail++; $display("FAIL overrun_next_count: got %0d expected 1", got_q.size() - n0);
    end else begin
      n_checks++;
      if (got_q[n0] !== 8'h34) begin
        n_fail++; $display("FAIL overrun_next_data: got %h expected 34", got_q[n0]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n0, f0;
    logic [7:0] d;
    d = 8'hA5;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    rx_bit = d[4];
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({fifo_push, frame_err, break_det, overrun, busy, fifo_data} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_async: got push=%b ferr=%b brk=%b ovr=%b busy=%b data=%h expected all 0",
               fifo_push, frame_err, break_det, overrun, busy, fifo_data);
    end
    rx_bit = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    idle(20);
    n0 = got_q.size(); f0 = ferr_cnt;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
    // 0x7E with the divider rewritten during bit 2; the frame keeps DIV
    d = 8'h7E;
    last_start_cyc = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) freq_divider = 8'd9;
      send_bit(d[i], 1'b0);
    end
    send_bit(1'b1, 1'b0);
    idle(40);
    freq_divider = 8'(DIV);
    n_checks++;
    if (got_q.size() - n0 !== 1) begin
      n_fail++; $display("FAIL post_reset_count: got %0d expected 1", got_q.size() - n0);
    end else begin
      n_checks++;
      if (got_q[n0] !== 8'h7E) begin
        n_fail++; $display("FAIL post_reset_data: got %h expected 7e", got_q[n0]);
      end
    end
    n_checks++;
    if (ferr_cnt !== f0) begin
      n_fail++; $display("FAIL post_reset_ferr: got %0d expected %0d", ferr_cnt, f0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
